// File: rtl/memmu_cartesian_representation_readback_if.sv
// Bus bundle for the MemMU cartesian representation readback block: control, memory read port
// and the outgoing point stream. slave = readback block, master = its environment.
interface memmu_cartesian_representation_readback_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 64
);
  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_num_points;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_mem_rd_en;
  logic [ADDR_WIDTH-1:0] o_mem_rd_addr;
  logic [DATA_WIDTH-1:0] i_mem_rd_data;
  logic                  o_pt_valid;
  logic                  i_pt_ready;
  logic [ADDR_WIDTH-1:0] o_pt_id;
  logic [DATA_WIDTH-1:0] o_pt_data;
  logic                  o_pt_last;

  modport slave (
    input  i_start, i_num_points, i_mem_rd_data, i_pt_ready,
    output o_busy, o_done, o_mem_rd_en, o_mem_rd_addr,
           o_pt_valid, o_pt_id, o_pt_data, o_pt_last
  );

  modport master (
    output i_start, i_num_points, i_mem_rd_data, i_pt_ready,
    input  o_busy, o_done, o_mem_rd_en, o_mem_rd_addr,
           o_pt_valid, o_pt_id, o_pt_data, o_pt_last
  );
endinterface

// File: rtl/memmu_cartesian_representation_readback.sv
// Scans addresses 0..N-1, tracks fixed-latency read returns and streams (id,data,last) through a
// credit-limited FIFO. Optional macro MEMMU_CR_READBACK_SKIP_EMPTY_EN drops all-zero (empty) cells.
module memmu_cartesian_representation_readback #(
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic i_SYSTEM_clk,
  input  logic i_SYSTEM_rst,
  memmu_cartesian_representation_readback_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} stateT;

  stateT                 stateReg, stateNext;
  logic [ADDR_WIDTH-1:0] cntReg, lastAddrReg;
  logic [CNT_W-1:0]      creditReg, fifoCountReg;
  logic [PTR_W-1:0]      wrPtrReg, rdPtrReg;
  logic                  rdEnReg, rdLastReg;
  logic [ADDR_WIDTH-1:0] rdAddrReg;

  logic                  pipeValid [MEM_LATENCY];
  logic                  pipeLast  [MEM_LATENCY];
  logic [ADDR_WIDTH-1:0] pipeId    [MEM_LATENCY];
  logic [ENTRY_W-1:0]    fifoMem   [FIFO_DEPTH];

  logic                  accept, numIsZero, creditOk, issue, issueLast;
  logic                  busy, done, pop, fifoWr, skipRet, retValid, ptValid;
  logic [ADDR_WIDTH-1:0] issueAddr, startLast;
  logic [ENTRY_W-1:0]    headEntry;

  assign accept    = (stateReg == IDLE) && bus.i_start;
  assign numIsZero = (bus.i_num_points == '0);
  assign startLast = bus.i_num_points - ADDR_WIDTH'(1);
  // The accepting cycle already issues address 0 so rd_en appears one cycle after start.
  assign issueAddr = (stateReg == IDLE) ? '0 : cntReg;
  assign issueLast = (issueAddr == ((stateReg == IDLE) ? startLast : lastAddrReg));

  assign ptValid = (fifoCountReg != '0);
  assign pop     = ptValid && bus.i_pt_ready;

  assign retValid = pipeValid[MEM_LATENCY-1];
`ifdef MEMMU_CR_READBACK_SKIP_EMPTY_EN
  assign skipRet = retValid && (bus.i_mem_rd_data == '0);
`else
  assign skipRet = 1'b0;
`endif
  assign fifoWr = retValid && !skipRet;

  // Slots freed this very cycle count toward the budget, sustaining one read per cycle.
  assign creditOk = (int'(creditReg) < FIFO_DEPTH + int'(pop) + int'(skipRet));

  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) stateReg <= IDLE;
    else               stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          if (numIsZero)              stateNext = DONE;
          else if (issue && issueLast) stateNext = DRAIN;
          else                        stateNext = RUN;
        end
      end
      RUN:     if (issue && issueLast) stateNext = DRAIN;
      DRAIN:   if (creditReg == '0)    stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy  = (stateReg != IDLE);
    done  = (stateReg == DONE);
    issue = 1'b0;
    if (creditOk) begin
      if (stateReg == RUN)              issue = 1'b1;
      else if (accept && !numIsZero)    issue = 1'b1;
    end
  end

  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      rdEnReg     <= 1'b0;
      rdAddrReg   <= '0;
      rdLastReg   <= 1'b0;
      cntReg      <= '0;
      lastAddrReg <= '0;
      creditReg   <= '0;
    end else begin
      rdEnReg   <= issue;
      rdLastReg <= issue && issueLast;
      if (issue) rdAddrReg <= issueAddr;
      if (accept) begin
        cntReg      <= ADDR_WIDTH'(1);
        lastAddrReg <= startLast;
      end else if (issue) begin
        cntReg <= cntReg + ADDR_WIDTH'(1);
      end
      creditReg <= creditReg + CNT_W'(issue) - CNT_W'(pop) - CNT_W'(skipRet);
    end
  end

  // Return tracker: stage 0 follows the registered read strobe, last stage lines up with read data.
  for (genvar gi = 0; gi < MEM_LATENCY; gi++) begin : gRetPipe
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
      if (!i_SYSTEM_rst) begin
        pipeValid[gi] <= 1'b0;
        pipeLast[gi]  <= 1'b0;
        pipeId[gi]    <= '0;
      end else if (gi == 0) begin
        pipeValid[gi] <= rdEnReg;
        pipeLast[gi]  <= rdLastReg;
        pipeId[gi]    <= rdAddrReg;
      end else begin
        pipeValid[gi] <= pipeValid[(gi == 0) ? 0 : gi-1];
        pipeLast[gi]  <= pipeLast[(gi == 0) ? 0 : gi-1];
        pipeId[gi]    <= pipeId[(gi == 0) ? 0 : gi-1];
      end
    end
  end

  always_ff @(posedge i_SYSTEM_clk) begin
    if (fifoWr) fifoMem[wrPtrReg] <= {pipeLast[MEM_LATENCY-1], pipeId[MEM_LATENCY-1], bus.i_mem_rd_data};
  end

  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      wrPtrReg     <= '0;
      rdPtrReg     <= '0;
      fifoCountReg <= '0;
    end else begin
      if (fifoWr) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (pop)    rdPtrReg <= rdPtrReg + PTR_W'(1);
      fifoCountReg <= fifoCountReg + CNT_W'(fifoWr) - CNT_W'(pop);
    end
  end

  assign headEntry = fifoMem[rdPtrReg];

  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
  assign bus.o_mem_rd_en   = rdEnReg;
  assign bus.o_mem_rd_addr = rdAddrReg;
  assign bus.o_pt_valid    = ptValid;
  assign bus.o_pt_data     = ptValid ? headEntry[DATA_WIDTH-1:0] : '0;
  assign bus.o_pt_id       = ptValid ? headEntry[DATA_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.o_pt_last     = ptValid && headEntry[ENTRY_W-1];
endmodule

// File: tb/tb_memmu_cartesian_representation_readback.sv
// Directed bench for the cartesian representation readback: reset, streaming, backpressure,
// empty runs and start-while-busy, against a 2-cycle latency memory model.
module tb_memmu_cartesian_representation_readback;
  localparam int AW    = 19;
  localparam int DW    = 64;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic sysClk = 1'b0;
  logic sysRstN;
  always #5 sysClk = ~sysClk;

  memmu_cartesian_representation_readback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busIf();

  memmu_cartesian_representation_readback #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_SYSTEM_clk(sysClk),
    .i_SYSTEM_rst(sysRstN),
    .bus(busIf)
  );

  int nChecks = 0;
  int nBad    = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: data valid two cycles after the read strobe, junk otherwise.
  logic [DW-1:0] memArr [32];
  logic          mEn, mRetV;
  logic [AW-1:0] mAddr;
  always @(posedge sysClk) begin
    mEn   <= busIf.o_mem_rd_en;
    mAddr <= busIf.o_mem_rd_addr;
    mRetV <= mEn;
    busIf.i_mem_rd_data <= mEn ? memArr[mAddr[4:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  int cycCnt = 0;
  always @(posedge sysClk) cycCnt <= cycCnt + 1;

  int            hsId[$];
  logic [DW-1:0] hsData[$];
  bit            hsLast[$];
  int            hsCyc[$];
  int rdEnCnt = 0, doneCnt = 0, doneCyc = 0, busyCnt = 0;
  int outstanding = 0, maxOut = 0, stallErr = 0;
  bit prevStall = 1'b0;
  int prevId = 0;
  logic [DW-1:0] prevData = '0;
  bit prevLast = 1'b0;

  always @(negedge sysClk) begin
    if (!sysRstN) begin
      outstanding = 0;
      prevStall   = 1'b0;
    end else begin
      if (busIf.o_mem_rd_en) begin
        rdEnCnt++;
        outstanding++;
      end
      if (outstanding > maxOut) maxOut = outstanding;
      if (busIf.o_busy) busyCnt++;
      if (busIf.o_done) begin
        doneCnt++;
        doneCyc = cycCnt;
      end
      if (prevStall && !(busIf.o_pt_valid && int'(busIf.o_pt_id) == prevId &&
                         busIf.o_pt_data == prevData && busIf.o_pt_last == prevLast))
        stallErr++;
      if (busIf.o_pt_valid && busIf.i_pt_ready) begin
        hsId.push_back(int'(busIf.o_pt_id));
        hsData.push_back(busIf.o_pt_data);
        hsLast.push_back(busIf.o_pt_last);
        hsCyc.push_back(cycCnt);
        outstanding--;
        $display("pt id=%0d data=%0d last=%0d cyc=%0d", busIf.o_pt_id, busIf.o_pt_data,
                 busIf.o_pt_last, cycCnt);
      end
`ifdef MEMMU_CR_READBACK_SKIP_EMPTY_EN
      if (mRetV && busIf.i_mem_rd_data == '0) outstanding--;
`endif
      prevStall = busIf.o_pt_valid && !busIf.i_pt_ready;
      prevId    = int'(busIf.o_pt_id);
      prevData  = busIf.o_pt_data;
      prevLast  = busIf.o_pt_last;
    end
  end

  task automatic checkQuiet(input string tag);
    checkVal({tag, ".busy"},  busIf.o_busy, 0);
    checkVal({tag, ".done"},  busIf.o_done, 0);
    checkVal({tag, ".rdEn"},  busIf.o_mem_rd_en, 0);
    checkVal({tag, ".valid"}, busIf.o_pt_valid, 0);
    checkVal({tag, ".id"},    busIf.o_pt_id, 0);
    checkVal({tag, ".data"},  busIf.o_pt_data, 0);
    checkVal({tag, ".last"},  busIf.o_pt_last, 0);
  endtask

  task automatic startRun(input int n, input int hold, output int sEdge);
    @(posedge sysClk);
    #1;
    busIf.i_start      = 1'b1;
    busIf.i_num_points = AW'(n);
    sEdge = cycCnt + 1;
    repeat (hold) @(posedge sysClk);
    #1 busIf.i_start = 1'b0;
  endtask

  task automatic runUntilDone(input int base, input bit toggle, input string tag);
    int n = 0;
    while (doneCnt <= base && n < 400) begin
      @(posedge sysClk);
      #1;
      if (toggle) busIf.i_pt_ready = ~busIf.i_pt_ready;
      n++;
    end
    repeat (3) @(posedge sysClk);
    #1;
    checkVal(tag, doneCnt - base, 1);
  endtask

  // Expected stream: ids 0..n-1, data id+100, last only on id n-1.
  task automatic checkStream(input string tag, input int base, input int n);
    checkVal({tag, ".count"}, hsId.size() - base, n);
    for (int k = 0; k < n && base + k < hsId.size(); k++) begin
      checkVal($sformatf("%s.id%0d", tag, k),   hsId[base+k], k);
      checkVal($sformatf("%s.data%0d", tag, k), hsData[base+k], k + 100);
      checkVal($sformatf("%s.last%0d", tag, k), hsLast[base+k], (k == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, sDummy, rdBase, hsBase, doneBase, busyBase, hsAtRst, rdAtRst, n;
    for (int a = 0; a < 32; a++) memArr[a] = 64'(a + 100);
    busIf.i_start      = 1'b0;
    busIf.i_num_points = '0;
    busIf.i_pt_ready   = 1'b0;
    sysRstN = 1'b1;
    #2 sysRstN = 1'b0;
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    checkQuiet("rst");
    @(posedge sysClk);
    #1 sysRstN = 1'b1;

    // Reset in the middle of a 16-point run after 5 reads.
    busIf.i_pt_ready = 1'b1;
    rdBase = rdEnCnt;
    startRun(16, 1, s);
    n = 0;
    while (rdEnCnt - rdBase < 5 && n < 50) begin
      @(negedge sysClk);
      #1;
      n++;
    end
    checkVal("midRst.reads", rdEnCnt - rdBase, 5);
    sysRstN = 1'b0;
    hsAtRst = hsId.size();
    rdAtRst = rdEnCnt;
    @(posedge sysClk);
    @(negedge sysClk);
    checkQuiet("midRst");
    @(posedge sysClk);
    #1 sysRstN = 1'b1;
    repeat (12) @(posedge sysClk);
    @(negedge sysClk);
    checkVal("midRst.noPt", hsId.size() - hsAtRst, 0);
    checkVal("midRst.noRd", rdEnCnt - rdAtRst, 0);
    checkVal("midRst.idle", busIf.o_busy, 0);

    // N=8 full-rate stream.
    busIf.i_pt_ready = 1'b1;
    rdBase = rdEnCnt; hsBase = hsId.size(); doneBase = doneCnt;
    startRun(8, 1, s);
    runUntilDone(doneBase, 1'b0, "full.done");
    checkStream("full", hsBase, 8);
    for (int k = 0; k < 8 && hsBase + k < hsCyc.size(); k++)
      checkVal($sformatf("full.cyc%0d", k), hsCyc[hsBase+k], s + 3 + k);
    checkVal("full.doneCyc", doneCyc, s + 12);
    checkVal("full.reads", rdEnCnt - rdBase, 8);

    // N=8 with ready toggling every cycle.
    busIf.i_pt_ready = 1'b1;
    rdBase = rdEnCnt; hsBase = hsId.size(); doneBase = doneCnt;
    startRun(8, 1, s);
    runUntilDone(doneBase, 1'b1, "toggle.done");
    checkStream("toggle", hsBase, 8);
    checkVal("toggle.reads", rdEnCnt - rdBase, 8);

    // N=0 with start held two cycles: one done pulse, no reads.
    busIf.i_pt_ready = 1'b1;
    rdBase = rdEnCnt; doneBase = doneCnt; busyBase = busyCnt;
    startRun(0, 2, s);
    repeat (4) @(posedge sysClk);
    #1;
    checkVal("empty.doneCnt", doneCnt - doneBase, 1);
    checkVal("empty.doneCyc", doneCyc, s);
    checkVal("empty.busyCyc", busyCnt - busyBase, 1);
    checkVal("empty.reads", rdEnCnt - rdBase, 0);

    // N=6 held off for 20 cycles, with an ignored start mid-run.
    busIf.i_pt_ready = 1'b0;
    rdBase = rdEnCnt; hsBase = hsId.size(); doneBase = doneCnt;
    startRun(6, 1, s);
    repeat (20) @(posedge sysClk);
    @(negedge sysClk);
    checkVal("hold.reads", rdEnCnt - rdBase, 4);
    checkVal("hold.valid", busIf.o_pt_valid, 1);
    checkVal("hold.headId", busIf.o_pt_id, 0);
    checkVal("hold.headData", busIf.o_pt_data, 100);
    startRun(3, 1, sDummy);
    repeat (3) @(posedge sysClk);
    #1 busIf.i_pt_ready = 1'b1;
    runUntilDone(doneBase, 1'b0, "hold.done");
    checkStream("hold", hsBase, 6);
    checkVal("hold.readsTotal", rdEnCnt - rdBase, 6);

`ifdef MEMMU_CR_READBACK_SKIP_EMPTY_EN
    memArr[0] = 64'd5; memArr[1] = 64'd0; memArr[2] = 64'd7;
    memArr[3] = 64'd0; memArr[4] = 64'd0; memArr[5] = 64'd9;
    busIf.i_pt_ready = 1'b1;
    hsBase = hsId.size(); doneBase = doneCnt;
    startRun(6, 1, s);
    runUntilDone(doneBase, 1'b0, "skip.done");
    checkVal("skip.count", hsId.size() - hsBase, 3);
    if (hsId.size() - hsBase >= 3) begin
      checkVal("skip.id0", hsId[hsBase], 0);     checkVal("skip.data0", hsData[hsBase], 5);
      checkVal("skip.id1", hsId[hsBase+1], 2);   checkVal("skip.data1", hsData[hsBase+1], 7);
      checkVal("skip.id2", hsId[hsBase+2], 5);   checkVal("skip.data2", hsData[hsBase+2], 9);
      checkVal("skip.last0", hsLast[hsBase], 0); checkVal("skip.last2", hsLast[hsBase+2], 1);
    end
`endif

    checkVal("outstandingLe4", (maxOut <= DEPTH), 1);
    checkVal("stallStable", stallErr, 0);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
